// File: rtl/fetch_stage_if.sv
// Fetch stage bus: redirect/stall controls, instruction-memory port and
// the IF/ID bundle plus fetch counter. master = fetch stage, slave = peer.
interface fetch_stage_if;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] imem_instr;
  logic [31:0] imem_addr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_next;
  logic        if_id_valid;
  logic [15:0] fetch_count;

  modport master (
    input  stall,
    input  flush,
    input  branch_taken,
    input  branch_target,
    input  jump,
    input  jump_index,
    input  imem_instr,
    output imem_addr,
    output if_id_instr,
    output if_id_pc,
    output if_id_pc_next,
    output if_id_valid,
    output fetch_count
  );

  modport slave (
    output stall,
    output flush,
    output branch_taken,
    output branch_target,
    output jump,
    output jump_index,
    output imem_instr,
    input  imem_addr,
    input  if_id_instr,
    input  if_id_pc,
    input  if_id_pc_next,
    input  if_id_valid,
    input  fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: word-addressed PC, one-cycle IF/ID capture, redirects,
// bubbles and a saturating fetch counter. Ports: clk, rst, bus (master).
package fetch_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        valid;
  } if_id_t;
endpackage

module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  fetch_stage_if.master bus
);

  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] pc_nxt;
  logic [31:0] jump_pc;
  logic        redirect;
  logic        bubble;
  logic        capture;
  if_id_t      if_id_q;
  if_id_t      if_id_d;
  logic [15:0] count_q;
  logic [15:0] count_d;

  assign pc_inc   = pc + 32'd1;
  assign jump_pc  = {pc[31:26], bus.jump_index};
  assign redirect = bus.branch_taken | bus.jump;
  assign bubble   = bus.flush | redirect;
  assign capture  = ~bubble & ~bus.stall;

  // Redirects outrank stall; branch outranks jump.
  always_comb begin
    pc_nxt = pc_inc;
    priority case (1'b1)
      bus.branch_taken: pc_nxt = bus.branch_target;
      bus.jump:         pc_nxt = jump_pc;
      bus.stall:        pc_nxt = pc;
      default:          pc_nxt = pc_inc;
    endcase
  end

  // A bubble keeps the old pc fields so decode still sees
  // where the squashed slot came from.
  always_comb begin
    if_id_d = if_id_q;
    priority case (1'b1)
      bubble: begin
        if_id_d.instr = NOP_WORD;
        if_id_d.valid = 1'b0;
      end
      bus.stall: if_id_d = if_id_q;
      default: begin
        if_id_d.instr   = bus.imem_instr;
        if_id_d.pc      = pc;
        if_id_d.pc_next = pc_inc;
        if_id_d.valid   = 1'b1;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (capture && count_q != 16'hFFFF)
      count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc              <= PC_RESET;
      if_id_q.instr   <= NOP_WORD;
      if_id_q.pc      <= 32'd0;
      if_id_q.pc_next <= 32'd0;
      if_id_q.valid   <= 1'b0;
      count_q         <= 16'd0;
    end else begin
      pc      <= pc_nxt;
      if_id_q <= if_id_d;
      count_q <= count_d;
    end
  end

  assign bus.imem_addr     = pc;
  assign bus.if_id_instr   = if_id_q.instr;
  assign bus.if_id_pc      = if_id_q.pc;
  assign bus.if_id_pc_next = if_id_q.pc_next;
  assign bus.if_id_valid   = if_id_q.valid;
  assign bus.fetch_count   = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: scenario tasks with a queue of expected
// snapshots pushed at drive time and popped after each edge.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  fetch_stage_if bus ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ipcn;
    logic        v;
    logic [15:0] cnt;
  } snap_t;

  typedef struct {
    string       name;
    logic        st;
    logic        fl;
    logic        br;
    logic [31:0] tgt;
    logic        jp;
    logic [25:0] idx;
    snap_t       e;
  } stim_t;

  snap_t sbq[$];
  int nvec = 0;
  int nerr = 0;

  function automatic logic [31:0] w(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0022_1820;
      32'd1:   return 32'h2109_000A;
      32'd2:   return 32'h8C43_0004;
      32'd3:   return 32'hAC64_0008;
      default: return a ^ 32'h5A5A_C3C3;
    endcase
  endfunction

  assign bus.imem_instr = w(bus.imem_addr);

  function automatic snap_t mk(input logic [31:0] pc, instr, ipc, ipcn,
                               input logic v, input logic [15:0] cnt);
    snap_t s;
    s.pc = pc; s.instr = instr; s.ipc = ipc;
    s.ipcn = ipcn; s.v = v; s.cnt = cnt;
    return s;
  endfunction

  function automatic snap_t snap();
    return mk(bus.imem_addr, bus.if_id_instr, bus.if_id_pc,
              bus.if_id_pc_next, bus.if_id_valid, bus.fetch_count);
  endfunction

  function automatic stim_t sv(input string n, input logic st, fl, br,
                               input logic [31:0] tgt, input logic jp,
                               input logic [25:0] idx, input snap_t e);
    stim_t s;
    s.name = n; s.st = st; s.fl = fl; s.br = br;
    s.tgt = tgt; s.jp = jp; s.idx = idx; s.e = e;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.stall = s.st;
    bus.flush = s.fl;
    bus.branch_taken = s.br;
    bus.branch_target = s.tgt;
    bus.jump = s.jp;
    bus.jump_index = s.idx;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'd0;
    bus.jump = 1'b0;
    bus.jump_index = 26'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam logic [31:0] NOP = 32'h0;

  task automatic test_reset();
    snap_t got, e;
    bus.stall = 1'b1;
    bus.flush = 1'b0;
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'd55;
    bus.jump = 1'b1;
    bus.jump_index = 26'h3;
    #1 rst = 1'b1;
    #1;
    sbq.push_back(mk(32'd0, NOP, 32'd0, 32'd0, 1'b0, 16'd0));
    got = snap(); e = sbq.pop_front(); nvec++;
    if (got !== e) begin
      nerr++;
      $display("FAIL rst_async got %h exp %h", got, e);
    end
    @(posedge clk); #1;
    sbq.push_back(mk(32'd0, NOP, 32'd0, 32'd0, 1'b0, 16'd0));
    got = snap(); e = sbq.pop_front(); nvec++;
    if (got !== e) begin
      nerr++;
      $display("FAIL rst_hold got %h exp %h", got, e);
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    sbq.push_back(mk(32'd1, w(0), 32'd0, 32'd1, 1'b1, 16'd1));
    drive(sv("rst_first", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0,
             mk(32'd1, w(0), 32'd0, 32'd1, 1'b1, 16'd1)));
    got = snap(); e = sbq.pop_front(); nvec++;
    if (got !== e) begin
      nerr++;
      $display("FAIL rst_first got %h exp %h", got, e);
    end
  endtask

  task automatic test_sequential();
    stim_t t[3];
    snap_t got, e;
    do_reset();
    t[0] = sv("seq1", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0,
              mk(32'd1, w(0), 32'd0, 32'd1, 1'b1, 16'd1));
    t[1] = sv("seq2", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0,
              mk(32'd2, w(1), 32'd1, 32'd2, 1'b1, 16'd2));
    t[2] = sv("seq3", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0,
              mk(32'd3, w(2), 32'd2, 32'd3, 1'b1, 16'd3));
    foreach (t[i]) begin
      sbq.push_back(t[i].e);
      drive(t[i]);
      got = snap(); e = sbq.pop_front(); nvec++;
      if (got !== e) begin
        nerr++;
        $display("FAIL %s got %h exp %h", t[i].name, got, e);
      end
    end
  endtask

  task automatic test_stall();
    stim_t t[5];
    snap_t got, e;
    do_reset();
    t[0] = sv("stl_pre1", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0,
              mk(32'd1, w(0), 32'd0, 32'd1, 1'b1, 16'd1));
    t[1] = sv("stl_pre2", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0,
              mk(32'd2, w(1), 32'd1, 32'd2, 1'b1, 16'd2));
    t[2] = sv("stl_hold1", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0,
              mk(32'd2, w(1), 32'd1, 32'd2, 1'b1, 16'd2));
    t[3] = sv("stl_hold2", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0,
              mk(32'd2, w(1), 32'd1, 32'd2, 1'b1, 16'd2));
    t[4] = sv("stl_rel", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0,
              mk(32'd3, w(2), 32'd2, 32'd3, 1'b1, 16'd3));
    foreach (t[i]) begin
      sbq.push_back(t[i].e);
      drive(t[i]);
      got = snap(); e = sbq.pop_front(); nvec++;
      if (got !== e) begin
        nerr++;
        $display("FAIL %s got %h exp %h", t[i].name, got, e);
      end
    end
  endtask

  task automatic test_branch();
    stim_t t[3];
    snap_t got, e;
    t[0] = sv("br_pre", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0,
              mk(32'd4, w(3), 32'd3, 32'd4, 1'b1, 16'd4));
    t[1] = sv("br_take", 1'b0, 1'b0, 1'b1, 32'd15, 1'b0, 26'd0,
              mk(32'd15, NOP, 32'd3, 32'd4, 1'b0, 16'd4));
    t[2] = sv("br_after", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0,
              mk(32'd16, w(15), 32'd15, 32'd16, 1'b1, 16'd5));
    foreach (t[i]) begin
      sbq.push_back(t[i].e);
      drive(t[i]);
      got = snap(); e = sbq.pop_front(); nvec++;
      if (got !== e) begin
        nerr++;
        $display("FAIL %s got %h exp %h", t[i].name, got, e);
      end
    end
  endtask

  task automatic test_jump_priority();
    stim_t t[5];
    snap_t got, e;
    t[0] = sv("jp_setup", 1'b0, 1'b0, 1'b1, 32'h0400_0003, 1'b0, 26'd0,
              mk(32'h0400_0003, NOP, 32'd15, 32'd16, 1'b0, 16'd5));
    t[1] = sv("jp_jump", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h5,
              mk(32'h0400_0005, NOP, 32'd15, 32'd16, 1'b0, 16'd5));
    t[2] = sv("jp_br_wins", 1'b0, 1'b0, 1'b1, 32'd9, 1'b1, 26'h5,
              mk(32'd9, NOP, 32'd15, 32'd16, 1'b0, 16'd5));
    t[3] = sv("jp_after", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0,
              mk(32'd10, w(9), 32'd9, 32'd10, 1'b1, 16'd6));
    t[4] = sv("jp_over_stall", 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 26'h7,
              mk(32'd7, NOP, 32'd9, 32'd10, 1'b0, 16'd6));
    foreach (t[i]) begin
      sbq.push_back(t[i].e);
      drive(t[i]);
      got = snap(); e = sbq.pop_front(); nvec++;
      if (got !== e) begin
        nerr++;
        $display("FAIL %s got %h exp %h", t[i].name, got, e);
      end
    end
  endtask

  task automatic test_flush();
    stim_t t[4];
    snap_t got, e;
    t[0] = sv("fl_pre", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0,
              mk(32'd8, w(7), 32'd7, 32'd8, 1'b1, 16'd7));
    t[1] = sv("fl_stall", 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0,
              mk(32'd8, NOP, 32'd7, 32'd8, 1'b0, 16'd7));
    t[2] = sv("fl_only", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0,
              mk(32'd9, NOP, 32'd7, 32'd8, 1'b0, 16'd7));
    t[3] = sv("fl_after", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0,
              mk(32'd10, w(9), 32'd9, 32'd10, 1'b1, 16'd8));
    foreach (t[i]) begin
      sbq.push_back(t[i].e);
      drive(t[i]);
      got = snap(); e = sbq.pop_front(); nvec++;
      if (got !== e) begin
        nerr++;
        $display("FAIL %s got %h exp %h", t[i].name, got, e);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t t[3];
    snap_t got, e;
    t[0] = sv("wr_top", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 26'd0,
              mk(32'hFFFF_FFFF, NOP, 32'd9, 32'd10, 1'b0, 16'd8));
    t[1] = sv("wr_wrap", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0,
              mk(32'd0, w(32'hFFFF_FFFF), 32'hFFFF_FFFF, 32'd0,
                 1'b1, 16'd9));
    t[2] = sv("wr_after", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0,
              mk(32'd1, w(0), 32'd0, 32'd1, 1'b1, 16'd10));
    foreach (t[i]) begin
      sbq.push_back(t[i].e);
      drive(t[i]);
      got = snap(); e = sbq.pop_front(); nvec++;
      if (got !== e) begin
        nerr++;
        $display("FAIL %s got %h exp %h", t[i].name, got, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    snap_t got, e;
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'd77;
    #2 rst = 1'b1;
    #1 idle();
    #1 rst = 1'b0;
    #1;
    sbq.push_back(mk(32'd0, NOP, 32'd0, 32'd0, 1'b0, 16'd0));
    got = snap(); e = sbq.pop_front(); nvec++;
    if (got !== e) begin
      nerr++;
      $display("FAIL rmid_reset got %h exp %h", got, e);
    end
    sbq.push_back(mk(32'd1, w(0), 32'd0, 32'd1, 1'b1, 16'd1));
    drive(sv("rmid_first", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0,
             mk(32'd1, w(0), 32'd0, 32'd1, 1'b1, 16'd1)));
    got = snap(); e = sbq.pop_front(); nvec++;
    if (got !== e) begin
      nerr++;
      $display("FAIL rmid_first got %h exp %h", got, e);
    end
  endtask

  task automatic test_saturate();
    snap_t got, e;
    do_reset();
    idle();
    repeat (65535) @(posedge clk);
    #1;
    sbq.push_back(mk(32'd65535, w(32'd65534), 32'd65534, 32'd65535,
                     1'b1, 16'hFFFF));
    got = snap(); e = sbq.pop_front(); nvec++;
    if (got !== e) begin
      nerr++;
      $display("FAIL sat_reach got %h exp %h", got, e);
    end
    sbq.push_back(mk(32'd65536, w(32'd65535), 32'd65535, 32'd65536,
                     1'b1, 16'hFFFF));
    @(posedge clk); #1;
    got = snap(); e = sbq.pop_front(); nvec++;
    if (got !== e) begin
      nerr++;
      $display("FAIL sat_hold got %h exp %h", got, e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump_priority();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
- REQ-001 Parameter PC_RESET, default 32'h0000_0000, word address loaded into the PC on reset.
- REQ-002 Parameter NOP_WORD, default 32'h0000_0000, instruction word inserted into IF/ID on a bubble.
- REQ-003 clk  input  1  single clock; all state updates on its rising edge.
- REQ-004 rst  input  1  reset, asynchronous and active-high.
- REQ-005 stall  input  1  holds the PC and the IF/ID register.
- REQ-006 flush  input  1  invalidates IF/ID on the next edge.
- REQ-007 branch_taken  input  1  redirects the PC to branch_target.
- REQ-008 branch_target  input  32  branch destination word address.
- REQ-009 jump  input  1  redirects the PC to {pc[31:26], jump_index}.
- REQ-010 jump_index  input  26  jump field of the instruction.
- REQ-011 imem_instr  input  32  instruction returned combinationally by the instruction memory for imem_addr.
- REQ-012 imem_addr  output  32  current PC, driven to the instruction memory addr port.
- REQ-013 if_id_instr  output  32  registered instruction for decode.
- REQ-014 if_id_pc  output  32  PC of if_id_instr.
- REQ-015 if_id_pc_next  output  32  if_id_pc + 1.
- REQ-016 if_id_valid  output  1  if_id_instr is a real fetched instruction.
- REQ-017 fetch_count  output  16  number of valid instructions captured into IF/ID.

Function
- REQ-018 The PC shall be a word address, with imem_addr = pc combinationally; the sequential increment shall be +1, modulo 2^32.
- REQ-019 The next PC shall be selected in this strict priority: branch_taken -> branch_target; jump -> {pc[31:26], jump_index}; stall -> pc; otherwise pc+1.
- REQ-020 A redirect (branch_taken or jump) shall override stall for the PC.
- REQ-021 IF/ID update priority:
  - flush or redirect -> if_id_instr=NOP_WORD, if_id_valid=0, if_id_pc/if_id_pc_next hold;
  - stall -> all IF/ID fields hold;
  - otherwise -> if_id_instr=imem_instr, if_id_pc=pc, if_id_pc_next=pc+1, if_id_valid=1.
- REQ-022 Fetch latency shall be one cycle: the word at PC n shall appear on if_id_instr on the edge that advances the PC from n.
- REQ-023 fetch_count shall increment by 1 only on edges that set if_id_valid=1 via a capture, and shall saturate at 16'hFFFF.
- REQ-024 When stall is high with no redirect and no flush, no state shall change, including fetch_count.
- REQ-025 When branch_taken and jump are both high, the branch shall win, and a single bubble shall be inserted.
- REQ-026 At pc=32'hFFFF_FFFF with no stall, the next PC shall be 32'h0000_0000, and if_id_pc_next shall also wrap to 0.

Reset
- REQ-027 Asserting rst shall immediately force:
  - pc=PC_RESET;
  - if_id_instr=NOP_WORD;
  - if_id_pc=0, if_id_pc_next=0;
  - if_id_valid=0;
  - fetch_count=0.
- REQ-028 While rst is high, all other inputs shall be ignored; the first rising edge after rst falls shall capture the word at PC_RESET.
- REQ-029 rst asserted mid-stall or mid-redirect shall discard the pending operation without any partial update.

Verification
- REQ-030 Sequential fetch: reset, then 3 clean edges.
  - Edge 1 -> if_id_instr=32'h0022_1820, if_id_pc=0, valid=1.
  - Edge 2 -> if_id_instr=32'h2109_000A, if_id_pc=1.
  - After edge 3 -> pc=3 and fetch_count=3.
- REQ-031 Stall: at pc=2, hold stall for 2 edges -> pc stays 2, IF/ID unchanged, fetch_count unchanged; on release, the next edge captures word 2 and pc=3.
- REQ-032 Branch: at pc=4, branch_taken=1 with branch_target=15 for one edge -> pc=15, if_id_valid=0, if_id_instr=0; the next edge gives if_id_pc=15 and valid=1.
- REQ-033 Jump and branch priority:
  - pc=32'h0400_0003, jump=1, jump_index=26'h5 -> pc=32'h0400_0005.
  - Same cycle with branch_taken=1 and target 9 -> pc=9.
- REQ-034 Flush, wrap and reset:
  - flush with stall -> valid=0 and pc held.
  - pc forced to 32'hFFFF_FFFF via branch -> next edge pc=0.
  - rst pulsed between edges -> outputs reach their reset values before the next edge.
